// File: rtl/obm_dma.sv
// obm_dma: copies one 256-byte CPU memory page into Object Memory through the VRAM write port.
// One trigger write starts the transfer; the bus is requested (optionally at vblank) and bytes stream across.
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 12
`endif

module obm_dma #(
    parameter int                          NUM_BYTES   = 256,
    parameter logic [`VRAM_ADDR_WIDTH-1:0] OBM_BASE    = 'h800,
    parameter bit                          WAIT_VBLANK = 1'b1
) (
    input  logic                        cpu_clk,
    input  logic                        rst,
    input  logic                        trigger_write,
    input  logic [7:0]                  trigger_data,
    input  logic                        vblank,
    output logic                        bus_req,
    input  logic                        bus_grant,
    output logic [15:0]                 src_address,
    output logic                        src_read,
    input  logic [7:0]                  src_data,
    output logic [`VRAM_ADDR_WIDTH-1:0] vram_address,
    output logic [7:0]                  data_out,
    output logic                        write_enable,
    output logic                        SELECT_obm,
    output logic                        busy,
    output logic                        done
);

    localparam int AW    = `VRAM_ADDR_WIDTH;
    localparam int IDX_W = 9;

    typedef enum logic [2:0] {IDLE, ARM, XFER, DRAIN, FINISH} state_t;

    state_t             state;
    logic [7:0]         page;
    logic [IDX_W-1:0]   rd_idx;
    logic [IDX_W-1:0]   wr_idx;
    logic               skid_valid;
    logic [7:0]         skid_data;

    always_ff @(posedge cpu_clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            page         <= '0;
            rd_idx       <= '0;
            wr_idx       <= '0;
            skid_valid   <= 1'b0;
            skid_data    <= '0;
            bus_req      <= 1'b0;
            src_address  <= '0;
            src_read     <= 1'b0;
            vram_address <= '0;
            data_out     <= '0;
            write_enable <= 1'b0;
            SELECT_obm   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            // NOTE: strobes default low each cycle so a missed branch can never leave one stuck high.
            src_read     <= 1'b0;
            write_enable <= 1'b0;
            SELECT_obm   <= 1'b0;
            done         <= 1'b0;

            // Write path: src_data belongs to the read strobed in the current cycle. The skid entry
            // is always older than any in-flight read because reads stop while it is occupied.
            if (state == XFER || state == DRAIN) begin
                if (bus_grant && (skid_valid || src_read)) begin
                    write_enable <= 1'b1;
                    SELECT_obm   <= 1'b1;
                    data_out     <= skid_valid ? skid_data : src_data;
                    vram_address <= OBM_BASE + AW'(wr_idx[7:0]);
                    wr_idx       <= wr_idx + IDX_W'(1);
                    skid_valid   <= 1'b0;
                end else if (src_read) begin
                    skid_valid <= 1'b1;
                    skid_data  <= src_data;
                end
            end

            case (state)
                IDLE: begin
                    if (trigger_write) begin
                        page   <= trigger_data;
                        rd_idx <= '0;
                        wr_idx <= '0;
                        busy   <= 1'b1;
                        state  <= ARM;
                    end
                end
                ARM: begin
                    if (bus_req && bus_grant) begin
                        bus_req <= 1'b1;
                        state   <= XFER;
                    end else begin
                        bus_req <= vblank || !WAIT_VBLANK;
                    end
                end
                XFER: begin
                    bus_req <= 1'b1;
                    if (bus_grant && !skid_valid) begin
                        src_read    <= 1'b1;
                        src_address <= {page, rd_idx[7:0]};
                        rd_idx      <= rd_idx + IDX_W'(1);
                        if (rd_idx == IDX_W'(NUM_BYTES - 1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (wr_idx == IDX_W'(NUM_BYTES)) begin
                        bus_req <= 1'b0;
                        done    <= 1'b1;
                        state   <= FINISH;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
